// File: rtl/leaf_ctrl_pkg.sv
// Shared definitions for the per-leaf control sequencer: command opcodes,
// FSM states and default sizing.
package leaf_ctrl_pkg;

  // Command opcodes carried on cmd_op
  typedef enum logic [1:0] {
    OP_NOP    = 2'd0,
    OP_RESET  = 2'd1,
    OP_START  = 2'd2,
    OP_RESEND = 2'd3
  } op_e;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RST    = 3'd1,
    S_GAP    = 3'd2,
    S_START  = 3'd3,
    S_RESEND = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Default sizing for an eight-leaf page
  localparam int DEF_NUM_LEAF = 8;
  localparam int DEF_RST_CYC  = 16;
  localparam int DEF_GAP_CYC  = 4;
  localparam int DEF_CNT_W    = 8;

endpackage : leaf_ctrl_pkg

// File: rtl/leaf_ctrl_seq.sv
// Command-driven sequencer for the per-leaf reset, ap_start and resend pins.
// One command is in flight at a time; a single down-counter times the reset
// hold, the post-reset quiet gap and the resend pulse.
module leaf_ctrl_seq
  import leaf_ctrl_pkg::*;
#(
  parameter int NUM_LEAF = DEF_NUM_LEAF,
  parameter int RST_CYC  = DEF_RST_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [NUM_LEAF-1:0] cmd_mask,
  input  logic [CNT_W-1:0]    cmd_len,
  output logic [NUM_LEAF-1:0] leaf_reset,
  output logic [NUM_LEAF-1:0] leaf_ap_start,
  output logic [NUM_LEAF-1:0] leaf_resend,
  output logic                busy,
  output logic                done_pulse,
  output logic                err_pulse
);

  // Reject parameter sets whose cycle counts cannot be held by the counter
  if (RST_CYC < 1 || RST_CYC > (2 ** CNT_W) - 1) begin : gChkRst
    $error("leaf_ctrl_seq: RST_CYC must be in 1..2^CNT_W-1");
  end
  if (GAP_CYC < 0 || GAP_CYC > (2 ** CNT_W) - 1) begin : gChkGap
    $error("leaf_ctrl_seq: GAP_CYC must be in 0..2^CNT_W-1");
  end

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_LEAF-1:0]   mask_q;
  logic [NUM_LEAF-1:0]   running_q;
  logic [NUM_LEAF-1:0]   leafReset_q;
  logic [NUM_LEAF-1:0]   leafResend_q;
  logic                  done_q;
  logic                  err_q;

  logic                  accept_d;
  op_e                   op_d;
  logic                  err_d;
  logic                  reject_d;
  logic [CNT_W-1:0]      len_d;

  // Decode the offered command: acceptance, error against the running set,
  // and the effective resend length (zero means a single cycle)
  always_comb begin
    accept_d = cmd_valid && (state_q == S_IDLE);
    op_d     = op_e'(cmd_op);
    err_d    = 1'b0;
    case (op_d)
      OP_START:  err_d = (cmd_mask & running_q) != '0;
      OP_RESEND: err_d = (cmd_mask & ~running_q) != '0;
      default:   err_d = 1'b0;
    endcase
    reject_d = err_d || (op_d == OP_NOP) || (cmd_mask == '0);
    len_d    = (cmd_len == '0) ? CNT_W'(1) : cmd_len;
  end

  // Sequencer FSM with the shared counter and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mask_q       <= '0;
      running_q    <= '0;
      leafReset_q  <= '0;
      leafResend_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            mask_q <= cmd_mask;
            if (reject_d) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= err_d;
            end else begin
              case (op_d)
                OP_RESET: begin
                  state_q     <= S_RST;
                  cnt_q       <= CNT_W'(RST_CYC);
                  leafReset_q <= cmd_mask;
                  running_q   <= running_q & ~cmd_mask;
                end
                OP_START: begin
                  state_q <= S_START;
                end
                OP_RESEND: begin
                  state_q      <= S_RESEND;
                  cnt_q        <= len_d;
                  leafResend_q <= cmd_mask;
                end
                default: begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end
              endcase
            end
          end
        end

        S_RST: begin
          if (cnt_q <= CNT_W'(1)) begin
            leafReset_q <= '0;
            if (GAP_CYC == 0) begin
              state_q <= S_DONE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_GAP;
              cnt_q   <= CNT_W'(GAP_CYC);
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_GAP: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= S_DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_START: begin
          running_q <= running_q | mask_q;
          state_q   <= S_DONE;
          done_q    <= 1'b1;
        end

        S_RESEND: begin
          if (cnt_q <= CNT_W'(1)) begin
            leafResend_q <= '0;
            state_q      <= S_DONE;
            cnt_q        <= '0;
            done_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q      <= S_IDLE;
          cnt_q        <= '0;
          leafReset_q  <= '0;
          leafResend_q <= '0;
          done_q       <= 1'b0;
          err_q        <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign leaf_reset    = leafReset_q;
  assign leaf_resend   = leafResend_q;
  assign leaf_ap_start = running_q;
  assign done_pulse    = done_q;
  assign err_pulse     = err_q;

endmodule : leaf_ctrl_seq

// File: tb/tb_leaf_ctrl_seq.sv
// Self-checking bench for leaf_ctrl_seq: directed command table, a mid-command
// reset sequence and randomized commands against a timeline reference model.
module tb_leaf_ctrl_seq;

  localparam int NL  = 8;
  localparam int RST = 16;
  localparam int GAP = 4;
  localparam int CW  = 8;

  logic          clk;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [NL-1:0] cmd_mask;
  logic [CW-1:0] cmd_len;
  logic [NL-1:0] leaf_reset;
  logic [NL-1:0] leaf_ap_start;
  logic [NL-1:0] leaf_resend;
  logic          busy;
  logic          done_pulse;
  logic          err_pulse;

  int testsRun;
  int testsFailed;
  int acceptCnt;

  logic [NL-1:0] modelRun;

  typedef struct packed {
    logic [NL-1:0] rst;
    logic [NL-1:0] ap;
    logic [NL-1:0] rsd;
    logic          busy;
    logic          ready;
    logic          done;
    logic          err;
  } obs_t;

  typedef struct {
    logic [1:0]    op;
    logic [NL-1:0] mask;
    logic [CW-1:0] len;
    bit            hold;
    int            expLat;
    bit            expErr;
    logic [NL-1:0] expAp;
  } vec_t;

  vec_t vecs[10];

  leaf_ctrl_seq #(
    .NUM_LEAF (NL),
    .RST_CYC  (RST),
    .GAP_CYC  (GAP),
    .CNT_W    (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_mask      (cmd_mask),
    .cmd_len       (cmd_len),
    .leaf_reset    (leaf_reset),
    .leaf_ap_start (leaf_ap_start),
    .leaf_resend   (leaf_resend),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .err_pulse     (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshakes so held-valid commands can be checked for single accept
  always @(posedge clk) begin
    if (!reset && cmd_valid && cmd_ready) acceptCnt <= acceptCnt + 1;
  end

  function automatic obs_t sampleDut();
    obs_t o;
    o.rst   = leaf_reset;
    o.ap    = leaf_ap_start;
    o.rsd   = leaf_resend;
    o.busy  = busy;
    o.ready = cmd_ready;
    o.done  = done_pulse;
    o.err   = err_pulse;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Issue one command and check every cycle until the sequencer is idle again
  task automatic applyStimulus(input logic [1:0] op, input logic [NL-1:0] mask,
                               input logic [CW-1:0] len, input bit hold,
                               output int lat, output bit errSeen);
    logic [NL-1:0] runB, runA;
    bit            e, degen;
    int            d, lenEff, waitCnt, acc0;
    obs_t          exp, got;
    runB   = modelRun;
    e      = (op == 2'd2 && (mask & runB) != '0) || (op == 2'd3 && (mask & ~runB) != '0);
    degen  = e || op == 2'd0 || mask == '0;
    lenEff = (len == '0) ? 1 : int'(len);
    if (degen) begin
      d = 1; runA = runB;
    end else if (op == 2'd1) begin
      d = RST + GAP + 1; runA = runB & ~mask;
    end else if (op == 2'd2) begin
      d = 2; runA = runB | mask;
    end else begin
      d = lenEff + 1; runA = runB;
    end
    lat = 0;
    errSeen = 1'b0;
    waitCnt = 0;
    @(negedge clk);
    while (!cmd_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!cmd_ready) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL ready_timeout: cmd_ready got 0 expected 1 at %0t", $time);
      return;
    end
    acc0      = acceptCnt;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_len   = len;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    for (int k = 1; k <= d + 1; k++) begin
      @(negedge clk);
      if (k == d + 1) cmd_valid = 1'b0;
      exp.rst   = (op == 2'd1 && !degen && k <= RST) ? mask : '0;
      exp.rsd   = (op == 2'd3 && !degen && k <= lenEff) ? mask : '0;
      if (k == d + 1 || (op == 2'd1 && !degen) || (op == 2'd2 && !degen && k == 2))
        exp.ap = runA;
      else
        exp.ap = runB;
      exp.busy  = (k <= d);
      exp.ready = (k == d + 1);
      exp.done  = (k == d);
      exp.err   = (k == d) && e;
      got = sampleDut();
      checkOutput($sformatf("cycle op=%0d mask=%h k=%0d", op, mask, k), 64'(got), 64'(exp));
      if (got.done && lat == 0) begin
        lat     = k;
        errSeen = got.err;
      end
    end
    checkOutput("accept_count", 64'(acceptCnt - acc0), 64'd1);
    modelRun = runA;
  endtask

  initial begin
    int   lat;
    bit   errSeen;
    int   doneCnt;
    obs_t got;

    testsRun    = 0;
    testsFailed = 0;
    acceptCnt   = 0;
    modelRun    = '0;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = '0;
    cmd_mask    = '0;
    cmd_len     = '0;

    vecs[0] = '{2'd1, 8'h05, 8'd0, 1'b0, 21, 1'b0, 8'h00};
    vecs[1] = '{2'd2, 8'h05, 8'd0, 1'b0,  2, 1'b0, 8'h05};
    vecs[2] = '{2'd2, 8'h01, 8'd0, 1'b0,  1, 1'b1, 8'h05};
    vecs[3] = '{2'd3, 8'h04, 8'd3, 1'b0,  4, 1'b0, 8'h05};
    vecs[4] = '{2'd3, 8'h02, 8'd3, 1'b0,  1, 1'b1, 8'h05};
    vecs[5] = '{2'd3, 8'h01, 8'd0, 1'b0,  2, 1'b0, 8'h05};
    vecs[6] = '{2'd0, 8'hFF, 8'd0, 1'b0,  1, 1'b0, 8'h05};
    vecs[7] = '{2'd2, 8'h00, 8'd0, 1'b0,  1, 1'b0, 8'h05};
    vecs[8] = '{2'd1, 8'h01, 8'd0, 1'b1, 21, 1'b0, 8'h04};
    vecs[9] = '{2'd3, 8'h04, 8'd1, 1'b1,  2, 1'b0, 8'h04};

    @(posedge clk);
    @(negedge clk);
    got = sampleDut();
    checkOutput("reset_state", 64'(got), 64'({8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].mask, vecs[i].len, vecs[i].hold, lat, errSeen);
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d_err", i), 64'(errSeen), 64'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d_ap_start", i), 64'(leaf_ap_start), 64'(vecs[i].expAp));
    end

    // Reset arriving in the eighth cycle of a RESET command
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_mask  = 8'h03;
    cmd_len   = '0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("midreset_before", 64'(leaf_reset), 64'(8'h03));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    got = sampleDut();
    checkOutput("midreset_after", 64'(got), 64'({8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));
    reset    = 1'b0;
    modelRun = '0;
    doneCnt  = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_pulse) doneCnt++;
    end
    checkOutput("midreset_no_done", 64'(doneCnt), 64'd0);
    applyStimulus(2'd2, 8'h30, 8'd0, 1'b0, lat, errSeen);
    checkOutput("post_reset_start_lat", 64'(lat), 64'd2);

    // Randomized command stream against the reference timeline
    for (int i = 0; i < 60; i++) begin
      logic [1:0]    rOp;
      logic [NL-1:0] rMask;
      logic [CW-1:0] rLen;
      bit            rHold;
      rOp   = 2'($urandom_range(0, 3));
      rMask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      rLen  = 8'($urandom_range(0, 5));
      rHold = ($urandom_range(0, 3) == 0);
      applyStimulus(rOp, rMask, rLen, rHold, lat, errSeen);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule : tb_leaf_ctrl_seq
